// File: rtl/dffsre_bank_rot_mux_if.sv
// Purpose: control/data bundle for the dffsre_bank_rot_mux register bank.
// Latency: none (wires only); the bank registers everything behind it.
// Backpressure: none; every cycle's controls are consumed unconditionally.
// Ports: S/E/mode/wr_addr/D_in/sel/sel_mux flow master->slave,
//        out/rot_cnt flow slave->master. Clock and reset are not carried here.
interface dffsre_bank_rot_mux_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
);
    logic                   S;
    logic                   E;
    logic [1:0]             mode;
    logic [AW-1:0]          wr_addr;
    logic [DEPTH*WIDTH-1:0] D_in;
    logic                   sel;
    logic [AW-1:0]          sel_mux;
    logic [WIDTH-1:0]       out;
    logic [AW-1:0]          rot_cnt;

    modport master (
        output S, E, mode, wr_addr, D_in, sel, sel_mux,
        input  out, rot_cnt
    );

    modport slave (
        input  S, E, mode, wr_addr, D_in, sel, sel_mux,
        output out, rot_cnt
    );
endinterface

// File: rtl/dffsre_bank_rot_mux.sv
// Purpose: DEPTH x WIDTH enable/set/reset register bank with addressed write,
//          bulk load, circular rotate (with rotation counter) and registered read mux.
// Latency: writes land at the edge they are presented; read data appears one edge after sel_mux.
// Backpressure: none; all controls are acted on every cycle.
// Ports: C clock, R sync active-high reset (highest priority); bus carries
//        S (set), E (enable), mode, wr_addr, D_in, sel, sel_mux -> out, rot_cnt.
module dffsre_bank_rot_mux #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  C,
    input  logic                  R,
    dffsre_bank_rot_mux_if.slave  bus
);

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_WRITE  = 2'b01;
    localparam logic [1:0] MODE_LOAD   = 2'b10;
    localparam logic [1:0] MODE_ROTATE = 2'b11;

    logic [WIDTH-1:0] bank_q   [DEPTH];
    logic [WIDTH-1:0] bank_d   [DEPTH];
    logic [WIDTH-1:0] nxt_dat  [DEPTH];
    logic [AW-1:0]    rot_cnt_q;
    logic [AW-1:0]    rot_cnt_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;

    // Per-entry candidate data: D_in slice, or the forced-ones preload.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            nxt_dat[i] = bus.sel ? bus.D_in[i*WIDTH +: WIDTH] : {WIDTH{1'b1}};
        end
    end

    // Bank / counter next state. Set overrides enable and mode.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            bank_d[i] = bank_q[i];
        end
        rot_cnt_d = rot_cnt_q;

        if (bus.S) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_d[i] = {WIDTH{1'b1}};
            end
        end else if (bus.E) begin
            case (bus.mode)
                MODE_HOLD: begin
                end
                MODE_WRITE: begin
                    // Out-of-range addresses (non power-of-two DEPTH) match no entry.
                    for (int i = 0; i < DEPTH; i++) begin
                        if (bus.wr_addr == AW'(i)) begin
                            bank_d[i] = nxt_dat[i];
                        end
                    end
                end
                MODE_LOAD: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        bank_d[i] = nxt_dat[i];
                    end
                    rot_cnt_d = '0;
                end
                MODE_ROTATE: begin
                    bank_d[0] = bank_q[DEPTH-1];
                    for (int i = 1; i < DEPTH; i++) begin
                        bank_d[i] = bank_q[i-1];
                    end
                    // Explicit wrap so the count is modulo DEPTH, not 2**AW.
                    rot_cnt_d = (rot_cnt_q == AW'(DEPTH-1)) ? '0 : rot_cnt_q + AW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Read mux samples pre-edge contents; unmatched selects read as zero.
    always_comb begin
        out_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.sel_mux == AW'(i)) begin
                out_d = bank_q[i];
            end
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
            rot_cnt_q <= '0;
            out_q     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= bank_d[i];
            end
            rot_cnt_q <= rot_cnt_d;
            out_q     <= out_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.rot_cnt = rot_cnt_q;

endmodule

// File: tb/tb_dffsre_bank_rot_mux.sv
module tb_dffsre_bank_rot_mux;

    logic C;
    logic r8;
    logic r6;
    int   tests;
    int   fails;

    dffsre_bank_rot_mux_if #(.WIDTH(4), .DEPTH(8)) b8 ();
    dffsre_bank_rot_mux_if #(.WIDTH(4), .DEPTH(6)) b6 ();

    dffsre_bank_rot_mux #(.WIDTH(4), .DEPTH(8)) dut8 (.C(C), .R(r8), .bus(b8));
    dffsre_bank_rot_mux #(.WIDTH(4), .DEPTH(6)) dut6 (.C(C), .R(r6), .bus(b6));

    initial C = 1'b0;
    always #5 C = ~C;

    typedef struct {
        logic        r;
        logic        s;
        logic        e;
        logic [1:0]  mode;
        logic [2:0]  wa;
        logic        sel;
        logic [31:0] d;
        logic [2:0]  sm;
        logic [3:0]  eo;
        logic [2:0]  er;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic s, logic e, logic [1:0] mode, logic [2:0] wa,
                                logic sel, logic [31:0] d, logic [2:0] sm,
                                logic [3:0] eo, logic [2:0] er);
        vec_t v;
        v.r = r; v.s = s; v.e = e; v.mode = mode; v.wa = wa;
        v.sel = sel; v.d = d; v.sm = sm; v.eo = eo; v.er = er;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Drive controls of the DEPTH=6 instance, let one edge pass, then check.
    task automatic step6(input string name, input int idx, input logic r, input logic s, input logic e,
                         input logic [1:0] mode, input logic [2:0] wa, input logic sel,
                         input logic [23:0] d, input logic [2:0] sm,
                         input logic [3:0] eo, input logic [2:0] er);
        r6 = r; b6.S = s; b6.E = e; b6.mode = mode; b6.wr_addr = wa;
        b6.sel = sel; b6.D_in = d; b6.sel_mux = sm;
        @(negedge C);
        chk({name, "_out"}, idx, 32'(b6.out), 32'(eo));
        chk({name, "_rot"}, idx, 32'(b6.rot_cnt), 32'(er));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        r8 = 1'b1; r6 = 1'b1;
        b8.S = 1'b0; b8.E = 1'b0; b8.mode = 2'b00; b8.wr_addr = '0;
        b8.sel = 1'b0; b8.D_in = '0; b8.sel_mux = '0;
        b6.S = 1'b0; b6.E = 1'b0; b6.mode = 2'b00; b6.wr_addr = '0;
        b6.sel = 1'b0; b6.D_in = '0; b6.sel_mux = '0;

        //                r  s  e  mode   wa  sel d             sm  out    rot
        // reset held two cycles with busy inputs
        vecs.push_back(mk(1, 1, 1, 2'b11, 3, 1, 32'hDEADBEEF, 2, 4'h0, 3'd0));
        vecs.push_back(mk(1, 0, 1, 2'b10, 5, 0, 32'h12345678, 7, 4'h0, 3'd0));
        // read back all entries after reset
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 32'h0, 3'(i), 4'h0, 3'd0));
        // forced-ones preload, then addressed write of A to entry 3
        vecs.push_back(mk(0, 0, 1, 2'b10, 0, 0, 32'h0,        0, 4'h0, 3'd0));
        vecs.push_back(mk(0, 0, 1, 2'b01, 3, 1, 32'h0000A000, 3, 4'hF, 3'd0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 32'h0,        3, 4'hA, 3'd0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 32'h0,        2, 4'hF, 3'd0));
        // load entry i = i, then nine rotates watching entry 0
        vecs.push_back(mk(0, 0, 1, 2'b10, 0, 1, 32'h76543210, 0, 4'hF, 3'd0));
        vecs.push_back(mk(0, 0, 1, 2'b11, 0, 0, 32'h0, 0, 4'h0, 3'd1));
        vecs.push_back(mk(0, 0, 1, 2'b11, 0, 0, 32'h0, 0, 4'h7, 3'd2));
        vecs.push_back(mk(0, 0, 1, 2'b11, 0, 0, 32'h0, 0, 4'h6, 3'd3));
        vecs.push_back(mk(0, 0, 1, 2'b11, 0, 0, 32'h0, 0, 4'h5, 3'd4));
        vecs.push_back(mk(0, 0, 1, 2'b11, 0, 0, 32'h0, 0, 4'h4, 3'd5));
        vecs.push_back(mk(0, 0, 1, 2'b11, 0, 0, 32'h0, 0, 4'h3, 3'd6));
        vecs.push_back(mk(0, 0, 1, 2'b11, 0, 0, 32'h0, 0, 4'h2, 3'd7));
        vecs.push_back(mk(0, 0, 1, 2'b11, 0, 0, 32'h0, 0, 4'h1, 3'd0));
        vecs.push_back(mk(0, 0, 1, 2'b11, 0, 0, 32'h0, 0, 4'h0, 3'd1));
        vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 32'h0, 0, 4'h7, 3'd1));
        vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 32'h0, 1, 4'h0, 3'd1));
        // set beats addressed write; disabled rotate changes nothing; reset beats set
        vecs.push_back(mk(0, 1, 1, 2'b01, 3, 1, 32'h0000A000, 1, 4'h0, 3'd1));
        vecs.push_back(mk(0, 0, 0, 2'b11, 0, 0, 32'h0, 1, 4'hF, 3'd1));
        vecs.push_back(mk(0, 0, 0, 2'b11, 0, 0, 32'h0, 4, 4'hF, 3'd1));
        vecs.push_back(mk(1, 1, 1, 2'b11, 0, 0, 32'h0, 4, 4'h0, 3'd0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 32'h0, 4, 4'h0, 3'd0));
        // read-during-write on entry 5: old value first, new value next
        vecs.push_back(mk(0, 0, 1, 2'b10, 0, 1, 32'h76543210, 0, 4'h0, 3'd0));
        vecs.push_back(mk(0, 0, 1, 2'b01, 5, 1, 32'h00600000, 5, 4'h5, 3'd0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 32'h0,        5, 4'h6, 3'd0));
        // reset in the middle of rotation, then resume from cleared state
        vecs.push_back(mk(0, 0, 1, 2'b11, 0, 0, 32'h0, 0, 4'h0, 3'd1));
        vecs.push_back(mk(1, 0, 1, 2'b11, 0, 0, 32'h0, 0, 4'h0, 3'd0));
        vecs.push_back(mk(0, 0, 1, 2'b11, 0, 0, 32'h0, 0, 4'h0, 3'd1));

        @(negedge C);
        for (int k = 0; k < vecs.size(); k++) begin
            r8 = vecs[k].r; b8.S = vecs[k].s; b8.E = vecs[k].e; b8.mode = vecs[k].mode;
            b8.wr_addr = vecs[k].wa; b8.sel = vecs[k].sel; b8.D_in = vecs[k].d;
            b8.sel_mux = vecs[k].sm;
            @(negedge C);
            chk("d8_out", k, 32'(b8.out), 32'(vecs[k].eo));
            chk("d8_rot", k, 32'(b8.rot_cnt), 32'(vecs[k].er));
        end

        // DEPTH=6: out-of-range write/read, and six rotates restoring contents
        step6("d6_rst",  0, 1, 0, 1, 2'b11, 0, 1, 24'hFFFFFF, 0, 4'h0, 3'd0);
        step6("d6_load", 0, 0, 0, 1, 2'b10, 0, 1, 24'h543210, 0, 4'h0, 3'd0);
        step6("d6_wr7",  0, 0, 0, 1, 2'b01, 7, 0, 24'h0,      0, 4'h0, 3'd0);
        step6("d6_wr6",  0, 0, 0, 1, 2'b01, 6, 0, 24'h0,      0, 4'h0, 3'd0);
        for (int i = 0; i < 6; i++)
            step6("d6_rdA", i, 0, 0, 0, 2'b00, 0, 0, 24'h0, 3'(i), 4'(i), 3'd0);
        step6("d6_sm6",  0, 0, 0, 0, 2'b00, 0, 0, 24'h0, 6, 4'h0, 3'd0);
        step6("d6_sm7",  0, 0, 0, 0, 2'b00, 0, 0, 24'h0, 7, 4'h0, 3'd0);
        for (int k = 0; k < 6; k++)
            step6("d6_rot", k, 0, 0, 1, 2'b11, 0, 0, 24'h0, 0,
                  4'((6 - k) % 6), 3'((k + 1) % 6));
        for (int i = 0; i < 6; i++)
            step6("d6_rdB", i, 0, 0, 0, 2'b00, 0, 0, 24'h0, 3'(i), 4'(i), 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dffsre_bank_rot_mux.md
# dffsre_bank_rot_mux

Parametrised register bank of DEPTH entries, each WIDTH bits wide, built from enable/set/reset flip-flop cells, with a registered read multiplexer. It generalises the fixed eight-flop, one-bit capture-and-select structure. It adds a configurable depth and width, per-entry addressed writes, bulk load with a forced-ones preload, circular rotation with a rotation counter, and a one-cycle registered read path. It sits between the capture datapath and downstream selection logic as a small storage-and-select stage.

## Interface
Parameters:
- WIDTH, 4, bits per entry (≥1)
- DEPTH, 8, number of entries (2..64, need not be a power of two)
- AW, $clog2(DEPTH), address/select width (derived, do not override)

Ports:
- C  input  1  clock; all state changes on rising edge
- R  input  1  reset, synchronous, active-high; highest priority
- S  input  1  synchronous set, active-high; second priority
- E  input  1  global enable for mode operations
- mode  input  2  00 hold, 01 addressed write, 10 bulk load, 11 rotate
- wr_addr  input  AW  target entry for mode 01
- D_in  input  DEPTH*WIDTH  entry i data at bits [i*WIDTH +: WIDTH]
- sel  input  1  data select for modes 01/10: 1 = D_in, 0 = all-ones constant
- sel_mux  input  AW  read select
- out  output  WIDTH  registered read data
- rot_cnt  output  AW  rotations performed modulo DEPTH

## Operation
- Storage: bank[0..DEPTH-1], each WIDTH bits; next-data per entry = sel ? D_in slice : {WIDTH{1'b1}}.
- Priority at each rising edge of C:
  - R=1: all entries 0, rot_cnt 0, out 0.
  - Else S=1: all entries all-ones. rot_cnt holds. E and mode are ignored.
  - Else E=0: entries and rot_cnt hold.
  - Else by mode:
    - 00: hold.
    - 01: bank[wr_addr] <= next-data[wr_addr]. If wr_addr ≥ DEPTH, no entry changes.
    - 10: every bank[i] <= next-data[i]; rot_cnt <= 0.
    - 11: bank[i] <= bank[i-1] for i≥1 and bank[0] <= bank[DEPTH-1]; rot_cnt <= (rot_cnt+1) mod DEPTH, wrapping DEPTH-1 → 0.
- Read path: when R=0, out <= bank[sel_mux] every cycle, independent of E, S and mode. It samples the pre-edge bank contents. If sel_mux ≥ DEPTH, out <= 0.
- rot_cnt arithmetic: AW bits with an explicit compare against DEPTH-1. It is not a natural power-of-two overflow.
- Reset values: out = 0, rot_cnt = 0, all bank entries 0.

## Timing
- Write latency: a write or load in cycle n updates bank at edge n. With sel_mux addressing that entry, out shows the new value after edge n+1 (2 edges from stimulus).
- Read latency: a sel_mux change at cycle n appears on out after edge n. No combinational path from sel_mux to out.
- Simultaneous write and read of the same entry in one cycle: out gets the old value.
- S in the same cycle as any mode: only the set applies; out still captures the pre-set value that cycle.
- R asserted mid-rotation or mid-sequence: everything is cleared at that edge. Operation resumes from the cleared state on the first edge with R=0.
- Rotate with DEPTH=2: the two entries swap each cycle and rot_cnt toggles 0/1.

## Test plan
- Reset: DEPTH=8, WIDTH=4, hold R=1 for 2 cycles with random inputs → out=0, rot_cnt=0. Then read all 8 entries → all return 0.
- Preload and addressed write: mode=10, sel=0, E=1 → all entries 4'hF. Then mode=01, wr_addr=3, sel=1, D_in slice3=4'hA. Then sel_mux=3 → out=4'hA two edges after the write; sel_mux=2 → out=4'hF.
- Rotate and wrap: bulk load entries i=i (sel=1), then 9 rotate cycles → rot_cnt=1 (wrapped through 0 after 8). Reading sel_mux=0 gives 4'h7; sel_mux=1 gives 4'h0.
- Priority: in one cycle assert S=1 with mode=01, E=1 → all entries 4'hF, rot_cnt unchanged. Then E=0 with mode=11 → no change. Then R=1 with S=1 → all 0.
- Read-during-write: sel_mux=5 while writing 4'h6 to entry 5 (old value 4'h5) → out=4'h5 after that edge, 4'h6 after the next.
- Non-power-of-two: DEPTH=6. wr_addr=7 write → no entry changes. sel_mux=6 → out=0. Six rotates → rot_cnt returns to 0 and contents are restored.
